// File: rtl/rom_stream_reader.sv
// Burst reader for an asynchronous-read byte ROM: walks base_addr..base_addr+length-1
// (wrapping modulo the address space) and streams bytes out over valid/ready.
module rom_stream_reader #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Next-state logic: start/length capture, ROM load into the output register, drain and abort.
  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length != CNT_W'(0)) begin
            rom_addr_d = base_addr;
            count_d    = length;
            state_d    = S_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = S_IDLE;
        end else if (!out_valid_q || out_ready) begin
          // Output register is empty or is being emptied at this edge.
          out_data_d  = rom_data;
          out_valid_d = 1'b1;
          out_last_d  = (count_q == CNT_W'(1));
          rom_addr_d  = rom_addr_q + ADDR_WIDTH'(1);
          count_d     = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (abort) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = S_IDLE;
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
